// File: rtl/tdr_pkg.sv
// Shared definitions for the TDR acquisition front end: FSM state type and
// default geometry of a capture.
package tdr_pkg;

  localparam int unsigned TDR_ADC_W  = 8;
  localparam int unsigned TDR_ADDR_W = 9;
  localparam int unsigned TDR_DEPTH  = 512;
  localparam int unsigned TDR_BLANK  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    ACQ  = 2'd2,
    DONE = 2'd3
  } tdr_state_e;

endpackage

// File: rtl/tdr_echo_detect.sv
// First-crossing latch: records the index of the first written sample at or
// above threshold once the blanking window has passed.
module tdr_echo_detect
  import tdr_pkg::*;
#(
  parameter int unsigned ADC_W  = TDR_ADC_W,
  parameter int unsigned ADDR_W = TDR_ADDR_W,
  parameter int unsigned BLANK  = TDR_BLANK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] idx,
  input  logic [ADC_W-1:0]  sample,
  input  logic [ADC_W-1:0]  thresh,
  output logic              found,
  output logic [ADDR_W-1:0] addr
);

  logic              r_found;
  logic [ADDR_W-1:0] r_addr;
  logic              w_hit;

  assign w_hit = wr_en & ~r_found & (32'(idx) >= BLANK) & (sample >= thresh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_found <= 1'b0;
      r_addr  <= '0;
    end else if (clear) begin
      r_found <= 1'b0;
      r_addr  <= '0;
    end else if (w_hit) begin
      r_found <= 1'b1;
      r_addr  <= idx;
    end
  end

  assign found = r_found;
  assign addr  = r_addr;

endmodule

// File: rtl/tdr_capture_ctrl.sv
// TDR capture controller: fires the excitation pulse, streams DEPTH decimated
// ADC samples into the sample RAM and hands the buffer over on completion.
module tdr_capture_ctrl
  import tdr_pkg::*;
#(
  parameter int unsigned ADC_W   = TDR_ADC_W,
  parameter int unsigned ADDR_W  = TDR_ADDR_W,
  parameter int unsigned DEPTH   = TDR_DEPTH,
  parameter int unsigned PULSE_W = 5,
  parameter int unsigned DECIM   = 1,
  parameter int unsigned BLANK   = TDR_BLANK
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADC_W-1:0]  thresh,
  input  logic [ADC_W-1:0]  adc_data,
  output logic              pulse_out,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [ADC_W-1:0]  ram_wr_data,
  output logic              busy,
  output logic              capture_done,
  output logic              data_valid,
  output logic              echo_found,
  output logic [ADDR_W-1:0] echo_addr
);

  localparam logic [7:0]        PULSE_LAST = 8'(PULSE_W - 1);
  localparam logic [7:0]        DECIM_LAST = 8'(DECIM - 1);
  localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   IDX_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  tdr_state_e        r_state;
  logic              r_start_d;
  logic [7:0]        r_pulse_cnt;
  logic [7:0]        r_decim_cnt;
  logic [ADDR_W:0]   r_sample_idx;
  logic              r_pulse;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADC_W-1:0]  r_wr_data;
  logic              r_done;
  logic              r_valid;

  logic              w_accept;
  logic              w_active;
  logic              w_strobe;
  logic              w_last_wr;

  assign w_accept  = (r_state == IDLE) & start & ~r_start_d & ~abort;
  assign w_active  = (r_state == FIRE) | (r_state == ACQ);
  assign w_strobe  = w_active & (r_decim_cnt == '0) & (r_sample_idx < DEPTH_L);
  assign w_last_wr = r_wr_en & (r_wr_addr == LAST_ADDR);

  // r_start_d resets high so a start level held through reset is not an edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= IDLE;
      r_start_d    <= 1'b1;
      r_pulse_cnt  <= '0;
      r_decim_cnt  <= '0;
      r_sample_idx <= '0;
      r_pulse      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_done       <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      r_start_d <= start;
      r_done    <= 1'b0;
      r_wr_en   <= w_strobe & ~abort;
      if (w_strobe) begin
        r_wr_addr    <= r_sample_idx[ADDR_W-1:0];
        r_wr_data    <= adc_data;
        r_sample_idx <= r_sample_idx + IDX_ONE;
      end
      if (w_active) begin
        r_decim_cnt <= (r_decim_cnt == DECIM_LAST) ? '0 : r_decim_cnt + 8'd1;
      end

      if (abort) begin
        r_state <= IDLE;
        r_pulse <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_state      <= FIRE;
              r_pulse      <= 1'b1;
              r_pulse_cnt  <= '0;
              r_decim_cnt  <= '0;
              r_sample_idx <= '0;
              r_valid      <= 1'b0;
            end
          end
          FIRE: begin
            if (r_pulse_cnt == PULSE_LAST) begin
              r_state <= ACQ;
              r_pulse <= 1'b0;
            end else begin
              r_pulse_cnt <= r_pulse_cnt + 8'd1;
            end
          end
          ACQ: begin
            if (w_last_wr) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_valid <= 1'b1;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  tdr_echo_detect #(
    .ADC_W (ADC_W),
    .ADDR_W(ADDR_W),
    .BLANK (BLANK)
  ) u_echo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .clear (w_accept),
    .wr_en (r_wr_en),
    .idx   (r_wr_addr),
    .sample(r_wr_data),
    .thresh(thresh),
    .found (echo_found),
    .addr  (echo_addr)
  );

  assign pulse_out    = r_pulse;
  assign ram_wr_en    = r_wr_en;
  assign ram_wr_addr  = r_wr_addr;
  assign ram_wr_data  = r_wr_data;
  assign busy         = w_active;
  assign capture_done = r_done;
  assign data_valid   = r_valid;

endmodule

// File: tb/tb_tdr_capture_ctrl.sv
// Directed bench for tdr_capture_ctrl: default instance plus a DECIM=4 instance,
// checked with immediate assertions against hand-derived expectations.
module tb_tdr_capture_ctrl;

  localparam int unsigned NONE = 100000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start4;
  logic       abort;
  logic [7:0] thresh;
  logic [7:0] adc;

  logic       p1, we1, busy1, done1, valid1, ef1;
  logic [8:0] wa1, ea1;
  logic [7:0] wd1;
  logic       p4, we4, busy4, done4, valid4, ef4;
  logic [8:0] wa4, ea4;
  logic [7:0] wd4;

  logic       mon4;
  logic       m_pulse, m_wr_en, m_busy, m_done, m_valid, m_echo_found;
  logic [8:0] m_wr_addr, m_echo_addr;
  logic [7:0] m_wr_data;

  int unsigned checks, errors;
  int unsigned nwr, pcnt, dcnt, dk, busy_lo, valid_at_done;
  logic [7:0]  drv [0:2111];

  always #5 clk = ~clk;

  tdr_capture_ctrl dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .abort(abort),
    .thresh(thresh), .adc_data(adc), .pulse_out(p1), .ram_wr_en(we1),
    .ram_wr_addr(wa1), .ram_wr_data(wd1), .busy(busy1), .capture_done(done1),
    .data_valid(valid1), .echo_found(ef1), .echo_addr(ea1)
  );

  tdr_capture_ctrl #(.DECIM(4)) dut4 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start4), .abort(abort),
    .thresh(thresh), .adc_data(adc), .pulse_out(p4), .ram_wr_en(we4),
    .ram_wr_addr(wa4), .ram_wr_data(wd4), .busy(busy4), .capture_done(done4),
    .data_valid(valid4), .echo_found(ef4), .echo_addr(ea4)
  );

  assign m_pulse      = mon4 ? p4     : p1;
  assign m_wr_en      = mon4 ? we4    : we1;
  assign m_wr_addr    = mon4 ? wa4    : wa1;
  assign m_wr_data    = mon4 ? wd4    : wd1;
  assign m_busy       = mon4 ? busy4  : busy1;
  assign m_done       = mon4 ? done4  : done1;
  assign m_valid      = mon4 ? valid4 : valid1;
  assign m_echo_found = mon4 ? ef4    : ef1;
  assign m_echo_addr  = mon4 ? ea4    : ea1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] adc_val(input int unsigned mode, input int unsigned k);
    logic [31:0] kv;
    kv = k;
    if (mode == 1) return (k < 16) ? 8'hFF : 8'd10;
    return kv[7:0];
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_pulse"},     32'(m_pulse),      0);
    check({tag, "_wr_en"},     32'(m_wr_en),      0);
    check({tag, "_wr_addr"},   32'(m_wr_addr),    0);
    check({tag, "_wr_data"},   32'(m_wr_data),    0);
    check({tag, "_busy"},      32'(m_busy),       0);
    check({tag, "_done"},      32'(m_done),       0);
    check({tag, "_valid"},     32'(m_valid),      0);
    check({tag, "_echo"},      32'(m_echo_found), 0);
    check({tag, "_echo_addr"}, 32'(m_echo_addr),  0);
  endtask

  // Raises start for the selected instance and checks the first FIRE cycle.
  task automatic launch(input logic sel4, input int unsigned mode);
    mon4 = sel4;
    nwr = 0; pcnt = 0; dcnt = 0; dk = 0; busy_lo = 0; valid_at_done = 0;
    if (sel4) start4 = 1'b1; else start = 1'b1;
    tick();
    check("fire_pulse", 32'(m_pulse),      1);
    check("fire_busy",  32'(m_busy),       1);
    check("fire_wr_en", 32'(m_wr_en),      0);
    check("fire_valid", 32'(m_valid),      0);
    check("fire_echo",  32'(m_echo_found), 0);
    pcnt = 1;
    adc = adc_val(mode, 0);
    drv[0] = adc;
  endtask

  // Sample n is the adc value driven after edge n*DECIM and appears on the
  // RAM port after edge n*DECIM+1, address n.
  task automatic run(input int unsigned n, input int unsigned mode,
                     input int unsigned abort_k, input int unsigned restart_k);
    int unsigned dec;
    dec = mon4 ? 4 : 1;
    for (int unsigned k = 1; k <= n; k++) begin
      tick();
      if (m_wr_en) begin
        check("wr_addr", 32'(m_wr_addr), nwr);
        if (nwr * dec < 2112) check("wr_data", 32'(m_wr_data), 32'(drv[nwr * dec]));
        check("wr_time", k, nwr * dec + 1);
        nwr++;
      end
      if (m_pulse) pcnt++;
      if (m_done) begin
        dcnt++;
        dk = k;
        valid_at_done = 32'(m_valid);
      end
      if (!m_busy && k <= 511 * dec + 1) busy_lo++;
      adc = adc_val(mode, k);
      if (k < 2112) drv[k] = adc;
      if (mon4) start4 = (k >= restart_k && k < restart_k + 4);
      else      start  = (k >= restart_k && k < restart_k + 4);
      abort = (k == abort_k);
    end
  endtask

  initial begin
    int unsigned act;
    checks = 0; errors = 0;
    nwr = 0; pcnt = 0; dcnt = 0; dk = 0; busy_lo = 0; valid_at_done = 0;
    rst_n = 1'b1; start = 1'b0; start4 = 1'b0; abort = 1'b0;
    thresh = 8'd0; adc = 8'd0; mon4 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_zero("rst");
    mon4 = 1'b1;
    check_zero("rst4");
    mon4 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    // Ramp capture, threshold 200
    thresh = 8'd200;
    launch(1'b0, 0);
    run(520, 0, NONE, NONE);
    check("t1_writes",     nwr,           512);
    check("t1_pulse_len",  pcnt,          5);
    check("t1_done_cnt",   dcnt,          1);
    check("t1_done_time",  dk,            513);
    check("t1_valid_done", valid_at_done, 1);
    check("t1_busy_gap",   busy_lo,       0);
    check("t1_busy_end",   32'(m_busy),       0);
    check("t1_valid",      32'(m_valid),      1);
    check("t1_echo",       32'(m_echo_found), 1);
    check("t1_echo_addr",  32'(m_echo_addr),  200);

    // Blanking: strong incident pulse inside the window only
    thresh = 8'd100;
    launch(1'b0, 1);
    run(520, 1, NONE, NONE);
    check("t2_writes",    nwr,                512);
    check("t2_done_cnt",  dcnt,               1);
    check("t2_echo",      32'(m_echo_found),  0);
    check("t2_echo_addr", 32'(m_echo_addr),   0);
    check("t2_valid",     32'(m_valid),       1);

    // Second start edge mid-capture is ignored
    thresh = 8'd200;
    launch(1'b0, 0);
    run(520, 0, NONE, 100);
    check("t3_writes",    nwr,     512);
    check("t3_pulse_len", pcnt,    5);
    check("t3_done_cnt",  dcnt,    1);
    check("t3_done_time", dk,      513);
    check("t3_busy_gap",  busy_lo, 0);

    // Abort just after sample 300 is written
    launch(1'b0, 0);
    run(302, 0, 301, NONE);
    check("t4_abort_wr_en", 32'(m_wr_en), 0);
    check("t4_abort_pulse", 32'(m_pulse), 0);
    check("t4_abort_busy",  32'(m_busy),  0);
    check("t4_abort_writes", nwr, 301);
    run(20, 0, NONE, NONE);
    check("t4_no_done",   dcnt,         0);
    check("t4_valid",     32'(m_valid), 0);
    check("t4_no_writes", nwr,          301);
    launch(1'b0, 0);
    run(520, 0, NONE, NONE);
    check("t4b_writes",   nwr,          512);
    check("t4b_done_cnt", dcnt,         1);
    check("t4b_valid",    32'(m_valid), 1);

    // DECIM=4 instance
    thresh = 8'd200;
    launch(1'b1, 0);
    run(2060, 0, NONE, NONE);
    check("t5_writes",     nwr,                512);
    check("t5_pulse_len",  pcnt,               5);
    check("t5_done_cnt",   dcnt,               1);
    check("t5_done_time",  dk,                 2046);
    check("t5_valid_done", valid_at_done,      1);
    check("t5_busy_gap",   busy_lo,            0);
    check("t5_echo",       32'(m_echo_found),  1);
    check("t5_echo_addr",  32'(m_echo_addr),   50);
    mon4 = 1'b0;

    // Async reset mid-capture, start held high across release
    thresh = 8'd20;
    launch(1'b0, 0);
    run(51, 0, NONE, NONE);
    check("t6_pre_echo",    32'(m_echo_found), 1);
    check("t6_pre_echo_at", 32'(m_echo_addr),  20);
    check("t6_pre_wr_data", 32'(m_wr_data),    50);
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    check_zero("arst");
    tick(); tick();
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_pulse || m_wr_en || m_busy) act++;
    end
    check("t6_no_false_start", act, 0);
    start = 1'b0;
    tick();
    launch(1'b0, 0);
    run(520, 0, NONE, NONE);
    check("t6_writes",    nwr,               512);
    check("t6_done_cnt",  dcnt,              1);
    check("t6_valid",     32'(m_valid),      1);
    check("t6_echo_addr", 32'(m_echo_addr),  20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdr_capture_ctrl.md
Name: tdr_capture_ctrl

Overview:
Upstream acquisition stage of the cable fault instrument. On a start request it fires the excitation pulse into the cable and streams 512 ADC samples into the shared sample RAM at a programmable decimation rate. It also flags the first sample index at or above a threshold after a blanking window, which is the echo position. On completion it hands the RAM to the UART readout stage via capture_done and data_valid.

Parameters:
ADC_W, 8, ADC sample width; equals RAM data width.
ADDR_W, 9, RAM address width.
DEPTH, 512, samples per capture; must equal 2**ADDR_W.
PULSE_W, 5, excitation pulse width in sys_clk cycles (100 ns at 50 MHz); range 1..255.
DECIM, 1, sys_clk cycles per stored sample; range 1..255.
BLANK, 16, leading samples excluded from echo detection (incident pulse).

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  asynchronous active-low reset
start  in  1  capture request; rising edge accepted only in IDLE
abort  in  1  synchronous abort; returns to IDLE, no done
thresh  in  ADC_W  echo detection threshold, unsigned
adc_data  in  ADC_W  ADC sample, already synchronous to sys_clk
pulse_out  out  1  excitation pulse to cable driver
ram_wr_en  out  1  RAM write strobe
ram_wr_addr  out  ADDR_W  RAM write address
ram_wr_data  out  ADC_W  RAM write data
busy  out  1  high in FIRE/ACQ
capture_done  out  1  one-cycle pulse when last sample written
data_valid  out  1  RAM holds a complete capture; cleared on next accepted start or abort
echo_found  out  1  threshold crossing detected in last capture
echo_addr  out  ADDR_W  index of first crossing; 0 if none

Behaviour:
- Reset: asynchronous; all outputs 0, state IDLE, counters 0.
- start edge detect: start_d registered; accept when start & ~start_d in IDLE. Edges outside IDLE are ignored (not queued).
- States: IDLE -> FIRE on accepted edge. FIRE -> ACQ after PULSE_W cycles. ACQ -> DONE after write of address DEPTH-1. DONE -> IDLE next cycle. abort from any state -> IDLE next cycle.
- Entry to FIRE clears data_valid, echo_found, and echo_addr; zeroes sample_idx and decim_cnt.
- pulse_out is high for exactly PULSE_W cycles, starting the cycle after the accepted edge.
- Sampling starts on the first FIRE cycle, so the incident pulse is recorded.
- Strobe: decim_cnt counts 0..DECIM-1 during FIRE/ACQ. A strobe occurs when decim_cnt==0.
- Strobe at cycle t: adc_data is captured. At t+1, ram_wr_en=1, ram_wr_data=sample, ram_wr_addr=sample_idx, after which sample_idx increments.
- Writes occur only on strobes; exactly DEPTH writes per capture, at addresses 0..DEPTH-1 with no wrap.
- If FIRE outlasts the first samples (PULSE_W > DECIM), strobes continue in FIRE. The FIRE->ACQ transition never drops or duplicates a sample.
- Echo: on each write with sample_idx >= BLANK, sample >= thresh, and echo_found==0, set echo_found=1 and echo_addr=sample_idx. Only the first crossing is kept. thresh is sampled continuously; a change mid-capture takes effect on the next write.
- DONE: capture_done is pulsed for one cycle, coincident with data_valid going high, one cycle after the final write. data_valid holds until the next accepted start or abort.
- busy is high from the first FIRE cycle through the final write, and low in DONE.
- abort: pulse_out and ram_wr_en drop the next cycle. A pending write of the in-flight sample is suppressed. data_valid stays 0 and no capture_done is issued.
- Async reset mid-capture: immediate return to reset values; RAM contents are undefined to consumers (data_valid=0).
- Width rules: all comparisons are unsigned. decim_cnt and pulse counters are 8 bits; sample_idx is ADDR_W+1 bits so DEPTH is detected without wrap.

Decomposition:
- Package tdr_pkg: state enum (IDLE, FIRE, ACQ, DONE), ADC_W/ADDR_W/DEPTH defaults.
- One sub-module, tdr_echo_detect: first-crossing latch with blanking, inputs wr_en/idx/sample/thresh/clear.
- Strobe, pulse, and FSM logic stay in the top module.

Test Plan:
- Defaults, thresh=200, ADC ramp 0..255 repeating, one start pulse -> pulse_out high 5 cycles. 512 writes at consecutive cycles, addr 0..511, data = ramp value one cycle earlier. capture_done one pulse; echo_found=1, echo_addr=200.
- DECIM=4 -> writes every 4th cycle, 512 writes total, last write at about 2048 cycles after start, no duplicate addresses.
- adc_data=255 during samples 0..15 then 10, thresh=100 -> echo_found=0, echo_addr=0 (blanking honoured).
- Second start edge at sample 100 -> ignored; exactly 512 writes; busy stays high.
- abort at sample 300 -> ram_wr_en low next cycle, no capture_done, data_valid=0. A new start then produces a full capture from addr 0.
- sys_rst_n low at sample 50 -> all outputs 0 immediately. After release with start held high, no capture occurs until a new rising edge.
